// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants, width helper and hex-to-segment decode
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    // Patterns are {a,b,c,d,e,f,g}, active-low
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0000010;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0010000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_mux_display_if.sv
// rtl/sseg_mux_display_if.sv - user-side image inputs and display pin outputs
interface sseg_mux_display_if #(
    parameter int N_DIGITS = 8
) ();
    logic [4*N_DIGITS-1:0] hex_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic                  lz_en;
    logic                  load;
    logic                  pending;
    logic                  frame_done;
    logic [N_DIGITS-1:0]   an;
    logic [7:0]            sseg;

    modport master (
        output hex_in, dp_in, blank_in, lz_en, load,
        input  pending, frame_done, an, sseg
    );

    modport slave (
        input  hex_in, dp_in, blank_in, lz_en, load,
        output pending, frame_done, an, sseg
    );
endinterface

// File: rtl/sseg_mux_display_refresh_timer.sv
// rtl/sseg_mux_display_refresh_timer.sv - slot prescaler, digit index and frame wrap
module sseg_refresh_timer
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    localparam int IW          = clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          tick,
    output logic          wrap,
    output logic [IW-1:0] digit_idx_nxt,
    output logic          in_blank_gap_nxt,
    output logic          frame_done
);
    localparam int PW = clog2(REFRESH_DIV);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [IW-1:0] digit_idx_q, digit_idx_d;
    logic          frame_done_q, frame_done_d;

    // Next-state values are exported so the output registers line up with the slot
    always_comb begin
        tick         = (prescaler_q == PW'(REFRESH_DIV - 1));
        wrap         = tick && (digit_idx_q == IW'(N_DIGITS - 1));
        prescaler_d  = tick ? '0 : prescaler_q + PW'(1);
        digit_idx_d  = digit_idx_q;
        if (wrap) begin
            digit_idx_d = '0;
        end else if (tick) begin
            digit_idx_d = digit_idx_q + IW'(1);
        end
        frame_done_d     = wrap;
        digit_idx_nxt    = digit_idx_d;
        in_blank_gap_nxt = (32'(prescaler_d) < BLANK_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler_q  <= '0;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            digit_idx_q  <= digit_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: rtl/sseg_mux_display.sv
// rtl/sseg_mux_display.sv - double-buffered multiplexed seven-segment driver
module sseg_mux_display
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    sseg_mux_display_if.slave   bus
);
    localparam int IW = clog2(N_DIGITS);

    logic                         tick, wrap, in_blank_gap_nxt, frame_done;
    logic [IW-1:0]                digit_idx_nxt;
    logic [N_DIGITS-1:0][3:0]     stage_hex_q, stage_hex_d, disp_hex_q, disp_hex_d;
    logic [N_DIGITS-1:0]          stage_dp_q, stage_dp_d, disp_dp_q, disp_dp_d;
    logic [N_DIGITS-1:0]          stage_blank_q, stage_blank_d, disp_blank_q, disp_blank_d;
    logic                         pending_q, pending_d;
    logic [N_DIGITS-1:0]          an_q, an_d;
    logic [7:0]                   sseg_q, sseg_d;
    logic [N_DIGITS-1:0]          suppress;
    logic                         zero_run, cur_dp, cur_blank, cur_supp;
    logic [3:0]                   cur_hex;

    sseg_refresh_timer #(
        .N_DIGITS    (N_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk             (clk),
        .reset_n         (reset_n),
        .tick            (tick),
        .wrap            (wrap),
        .digit_idx_nxt   (digit_idx_nxt),
        .in_blank_gap_nxt(in_blank_gap_nxt),
        .frame_done      (frame_done)
    );

    always_comb begin
        stage_hex_d   = stage_hex_q;
        stage_dp_d    = stage_dp_q;
        stage_blank_d = stage_blank_q;
        disp_hex_d    = disp_hex_q;
        disp_dp_d     = disp_dp_q;
        disp_blank_d  = disp_blank_q;
        pending_d     = pending_q;
        if (bus.load) begin
            stage_hex_d   = bus.hex_in;
            stage_dp_d    = bus.dp_in;
            stage_blank_d = bus.blank_in;
            pending_d     = 1'b1;
        end
        // A load landing on the wrap edge bypasses staging straight into the display
        if (wrap) begin
            if (bus.load) begin
                disp_hex_d   = bus.hex_in;
                disp_dp_d    = bus.dp_in;
                disp_blank_d = bus.blank_in;
            end else if (pending_q) begin
                disp_hex_d   = stage_hex_q;
                disp_dp_d    = stage_dp_q;
                disp_blank_d = stage_blank_q;
            end
            pending_d = 1'b0;
        end

        zero_run = bus.lz_en;
        suppress = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (disp_hex_d[i] == 4'h0);
            suppress[i] = zero_run;
        end

        cur_hex   = disp_hex_d[digit_idx_nxt];
        cur_dp    = disp_dp_d[digit_idx_nxt];
        cur_blank = disp_blank_d[digit_idx_nxt];
        cur_supp  = suppress[digit_idx_nxt];
        sseg_d    = {~cur_dp, cur_supp ? SEG_BLANK : hex_to_seg7(cur_hex)};
        an_d      = '1;
        if (!in_blank_gap_nxt && !cur_blank && (!cur_supp || cur_dp)) begin
            an_d[digit_idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_hex_q   <= '0;
            stage_dp_q    <= '0;
            stage_blank_q <= '0;
            disp_hex_q    <= '0;
            disp_dp_q     <= '0;
            disp_blank_q  <= '0;
            pending_q     <= 1'b0;
            an_q          <= '1;
            sseg_q        <= 8'hFF;
        end else begin
            stage_hex_q   <= stage_hex_d;
            stage_dp_q    <= stage_dp_d;
            stage_blank_q <= stage_blank_d;
            disp_hex_q    <= disp_hex_d;
            disp_dp_q     <= disp_dp_d;
            disp_blank_q  <= disp_blank_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            sseg_q        <= sseg_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done;
    assign bus.an         = an_q;
    assign bus.sseg       = sseg_q;

endmodule

// File: tb/tb_sseg_mux_display.sv
// tb/tb_sseg_mux_display.sv - scoreboard bench for sseg_mux_display
module tb_sseg_mux_display;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    typedef struct {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       chk_seg;
        int         digit;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sseg_mux_display_if #(.N_DIGITS(N)) bus ();

    sseg_mux_display #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    exp_t       sb[$];
    logic [15:0] m_hex   = '0;
    logic [3:0]  m_dp    = '0;
    logic [3:0]  m_blank = '0;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0000010;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0010000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic exp_t model_slot(input int d);
        exp_t e;
        logic supp;
        supp = bus.lz_en && (d >= 1);
        for (int j = d; j < N; j++) begin
            if (m_hex[4*j +: 4] != 4'h0) supp = 1'b0;
        end
        e.digit   = d;
        e.an      = 4'hF;
        e.sseg    = {~m_dp[d], supp ? 7'h7F : seg_of(m_hex[4*d +: 4])};
        e.chk_seg = !m_blank[d];
        if (!m_blank[d] && (!supp || m_dp[d])) e.an[d] = 1'b0;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc = cyc + n;
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
        bus.hex_in   = h;
        bus.dp_in    = dp;
        bus.blank_in = bl;
        bus.load     = 1'b1;
        step(1);
        bus.load     = 1'b0;
    endtask

    task automatic sync_frame();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.frame_done !== 1'b1 && t < 100);
        vectors++;
        if (bus.frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_sync: frame_done=%b, required 1 within 100 cycles", bus.frame_done);
        end
        cyc = 0;
    endtask

    // Called on the frame_done cycle; checks mid-slot of every digit
    task automatic scan_frame(input string tag);
        exp_t e;
        for (int d = 0; d < N; d++) sb.push_back(model_slot(d));
        for (int d = 0; d < N; d++) begin
            step(d * DIV + 4 - cyc);
            e = sb.pop_front();
            vectors++;
            if (bus.an !== e.an || (e.chk_seg && bus.sseg !== e.sseg)) begin
                miscompares++;
                $display("FAIL %s slot%0d: an=%b sseg=%h, required an=%b sseg=%h",
                         tag, e.digit, bus.an, bus.sseg, e.an, e.sseg);
            end
        end
    endtask

    task automatic check_pending(input string tag, input logic req);
        vectors++;
        if (bus.pending !== req) begin
            miscompares++;
            $display("FAIL %s: pending=%b, required %b", tag, bus.pending, req);
        end
    endtask

    task automatic test_reset();
        bus.hex_in = 16'hFFFF; bus.dp_in = 4'hF; bus.blank_in = 4'h0;
        bus.lz_en = 1'b0; bus.load = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.an !== 4'hF || bus.sseg !== 8'hFF || bus.pending !== 1'b0 || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: an=%b sseg=%h pending=%b frame_done=%b, required 1111 ff 0 0",
                     bus.an, bus.sseg, bus.pending, bus.frame_done);
        end
        reset_n = 1'b1;
        bus.load = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.an !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_gap: an=%b, required 1111", bus.an);
        end
        @(negedge clk);
        vectors++;
        if (bus.an !== 4'b1110 || bus.sseg !== 8'h81) begin
            miscompares++;
            $display("FAIL reset_first_anode: an=%b sseg=%h, required 1110 81", bus.an, bus.sseg);
        end
        check_pending("reset_pending_discard", 1'b0);
    endtask

    task automatic test_scan();
        int t;
        do_load(16'h12AF, 4'b0100, 4'b0000);
        check_pending("scan_pending_set", 1'b1);
        sync_frame();
        m_hex = 16'h12AF; m_dp = 4'b0100; m_blank = 4'b0000;
        check_pending("scan_pending_clear", 1'b0);
        scan_frame("scan");
        sync_frame();
        @(negedge clk);
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_width: frame_done=%b one cycle after pulse, required 0", bus.frame_done);
        end
        t = 1;
        while (bus.frame_done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t != FRAME) begin
            miscompares++;
            $display("FAIL frame_period: period=%0d cycles, required %0d", t, FRAME);
        end
        cyc = 0;
    endtask

    task automatic test_zero_suppress();
        bus.lz_en = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        sync_frame();
        m_hex = 16'h0050; m_dp = 4'b0000; m_blank = 4'b0000;
        scan_frame("lz_0050");
        do_load(16'h0000, 4'b0000, 4'b0000);
        sync_frame();
        m_hex = 16'h0000; m_dp = 4'b0000;
        scan_frame("lz_zero");
        do_load(16'h0000, 4'b0100, 4'b0000);
        sync_frame();
        m_dp = 4'b0100;
        scan_frame("lz_dp");
        bus.lz_en = 1'b0;
    endtask

    task automatic test_double_buffer();
        exp_t e;
        sync_frame();
        step(9);
        do_load(16'h1234, 4'b0000, 4'b0000);
        check_pending("dbuf_pending_mid", 1'b1);
        sb.push_back(model_slot(2));
        step(20 - cyc);
        e = sb.pop_front();
        vectors++;
        if (bus.an !== e.an || bus.sseg !== e.sseg) begin
            miscompares++;
            $display("FAIL dbuf_hold slot2: an=%b sseg=%h, required an=%b sseg=%h",
                     bus.an, bus.sseg, e.an, e.sseg);
        end
        do_load(16'h5678, 4'b0001, 4'b0000);
        step(30 - cyc);
        check_pending("dbuf_pending_late", 1'b1);
        sync_frame();
        check_pending("dbuf_pending_commit", 1'b0);
        m_hex = 16'h5678; m_dp = 4'b0001; m_blank = 4'b0000;
        scan_frame("dbuf_last_wins");
    endtask

    task automatic test_coincident();
        step(FRAME - 1 - cyc);
        bus.hex_in = 16'h9ABC; bus.dp_in = 4'b0010; bus.blank_in = 4'b0000;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        vectors++;
        if (bus.frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL coincident_wrap: frame_done=%b, required 1", bus.frame_done);
        end
        check_pending("coincident_pending", 1'b0);
        cyc = 0;
        m_hex = 16'h9ABC; m_dp = 4'b0010; m_blank = 4'b0000;
        scan_frame("coincident");
        check_pending("coincident_pending_end", 1'b0);
    endtask

    task automatic test_blank_mask();
        int bad;
        do_load(16'h4321, 4'b0000, 4'b1010);
        sync_frame();
        m_hex = 16'h4321; m_dp = 4'b0000; m_blank = 4'b1010;
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (bus.an[1] !== 1'b1 || bus.an[3] !== 1'b1) bad++;
            step(1);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL blank_mask: %0d cycles with an[1] or an[3] low, required 0", bad);
        end
        vectors++;
        if (bus.frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL blank_period: frame_done=%b after %0d cycles, required 1", bus.frame_done, FRAME);
        end
        cyc = 0;
        scan_frame("blank");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_zero_suppress();
        test_double_buffer();
        test_coincident();
        test_blank_mask();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
